// File: rtl/cic_decimator.sv
// CIC decimator: N-stage integrate/comb, decimate by R, 4-deep output FIFO.
// Define CIC_CLIP_DETECT_EN to add the sticky clip_o input-extreme flag.
module cic_decimator #(
   parameter int N_STAGES = 3,
   parameter int R        = 8,
   parameter int OUT_W    = 16
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic signed [11:0]      adc_i,
   input  logic                    ready_i,
   output logic signed [OUT_W-1:0] data_o,
   output logic                    valid_o,
   output logic                    ovf_o
`ifdef CIC_CLIP_DETECT_EN
   ,
   output logic                    clip_o
`endif
);

   localparam int LR    = $clog2(R);
   localparam int W     = 12 + N_STAGES * LR;
   localparam int DEPTH = 4;

   logic [W-1:0]     integ_q [N_STAGES];
   logic [W-1:0]     integ_d [N_STAGES];
   logic [W-1:0]     dly_q   [N_STAGES];
   logic [W-1:0]     dly_d   [N_STAGES];
   logic [W-1:0]     comb_x;
   logic [W-1:0]     comb_y;
   logic [OUT_W-1:0] comb_q, comb_d;
   logic             pend_q, pend_d;
   logic [LR-1:0]    cnt_q, cnt_d;
   logic [OUT_W-1:0] mem_q [DEPTH];
   logic [OUT_W-1:0] mem_d [DEPTH];
   logic [1:0]       rd_q, rd_d;
   logic [1:0]       wp_q, wp_d;
   logic [2:0]       fill_q, fill_d;
   logic             ovf_q, ovf_d;
   logic             strobe, full, pop, do_push;

   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      strobe = (cnt_q == LR'(R - 1));
      integ_d[0] = integ_q[0] + {{(W-12){adc_i[11]}}, adc_i};
      for (int k = 1; k < N_STAGES; k++) begin
         integ_d[k] = integ_q[k] + integ_q[k-1];
      end
      // Comb delays only advance on the decimated strobe.
      comb_x = integ_q[N_STAGES-1];
      comb_y = '0;
      for (int k = 0; k < N_STAGES; k++) begin
         dly_d[k] = dly_q[k];
         comb_y   = comb_x - dly_q[k];
         if (strobe) dly_d[k] = comb_x;
         comb_x   = comb_y;
      end
      comb_d = strobe ? comb_x[W-1 -: OUT_W] : comb_q;
      pend_d = strobe;
   end

   always_comb begin
      full    = (fill_q == 3'(DEPTH));
      pop     = valid_o & ready_i;
      do_push = pend_q & (~full | pop);
      mem_d   = mem_q;
      wp_d    = wp_q;
      rd_d    = rd_q;
      fill_d  = fill_q;
      if (do_push) begin
         mem_d[wp_q] = comb_q;
         wp_d        = wp_q + 2'd1;
      end
      if (pop) rd_d = rd_q + 2'd1;
      if (do_push & ~pop) fill_d = fill_q + 3'd1;
      else if (pop & ~do_push) fill_d = fill_q - 3'd1;
      ovf_d = ovf_q | (pend_q & full & ~pop);
   end

   assign valid_o = (fill_q != 3'd0);
   assign data_o  = mem_q[rd_q];
   assign ovf_o   = ovf_q;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         for (int k = 0; k < N_STAGES; k++) begin
            integ_q[k] <= '0;
            dly_q[k]   <= '0;
         end
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         comb_q <= '0;
         pend_q <= 1'b0;
         cnt_q  <= '0;
         rd_q   <= '0;
         wp_q   <= '0;
         fill_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         integ_q <= integ_d;
         dly_q   <= dly_d;
         mem_q   <= mem_d;
         comb_q  <= comb_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wp_q    <= wp_d;
         fill_q  <= fill_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef CIC_CLIP_DETECT_EN
   logic clip_q, clip_d;

   always_comb begin
      clip_d = clip_q | (adc_i == 12'sh7FF) | (adc_i == 12'sh800);
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) clip_q <= 1'b0;
      else         clip_q <= clip_d;
   end

   assign clip_o = clip_q;
`endif

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: convolution-based reference model plus
// directed vectors with hand-computed results.
module tb_cic_decimator;

   localparam int N     = 3;
   localparam int R     = 8;
   localparam int OUT_W = 16;
   localparam int W     = 21;
   localparam int NT    = N * (R - 1);

   typedef struct {
      logic signed [OUT_W-1:0] v;
      bit                      tr;
   } ent_t;

   logic                    clk = 1'b0;
   logic                    rstn_i = 1'b0;
   logic [11:0]             adc_i = '0;
   logic                    ready_i = 1'b0;
   logic signed [OUT_W-1:0] data_o;
   logic                    valid_o;
   logic                    ovf_o;
`ifdef CIC_CLIP_DETECT_EN
   logic                    clip_o;
`endif

   cic_decimator #(.N_STAGES(N), .R(R), .OUT_W(OUT_W)) dut (
      .clk_i   (clk),
      .rstn_i  (rstn_i),
      .adc_i   (adc_i),
      .ready_i (ready_i),
      .data_o  (data_o),
      .valid_o (valid_o),
      .ovf_o   (ovf_o)
`ifdef CIC_CLIP_DETECT_EN
      ,
      .clip_o  (clip_o)
`endif
   );

   always #8 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int c     = 0;
   int mode  = 0;

   // Reference: filter impulse response and input history since reset.
   int   h    [0:NT];
   int   hist [0:1023];
   int   mcyc = 0;
   int   m_nw = 0;
   bit   m_wr = 0;
   bit   m_wtr = 0;
   bit   m_ovf = 0;
   bit   m_written = 0;
   bit   m_clip = 0;
   logic signed [OUT_W-1:0] m_wval = '0;
   ent_t mq[$];

   task automatic chk(input string nm, input longint act,
                      input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic signed [OUT_W-1:0] ideal(input int n);
      longint     acc;
      logic [W-1:0] t;
      acc = 0;
      for (int j = 0; j <= NT; j++) begin
         if (n - N - j >= 0)
            acc += longint'(h[j]) * longint'(hist[n-N-j]);
      end
      t = acc[W-1:0];
      return t[W-1 -: OUT_W];
   endfunction

   task automatic model_step();
      int sz;
      bit pp;
      if (!rstn_i) begin
         mcyc = 0; m_nw = 0; m_wr = 0; m_ovf = 0;
         m_written = 0; m_clip = 0;
         mq.delete();
      end else begin
         sz = mq.size();
         pp = (sz > 0) && ready_i;
         if (pp) void'(mq.pop_front());
         if (m_wr) begin
            if (sz < 4 || pp) begin
               mq.push_back('{m_wval, m_wtr});
               m_written = 1;
            end else begin
               m_ovf = 1;
            end
         end
         if (mcyc < 1024) hist[mcyc] = int'($signed(adc_i));
         m_wr = (mcyc % R == R - 1);
         if (m_wr) begin
            m_wval = ideal(mcyc);
            m_wtr  = (m_nw < N + 1);
            m_nw++;
         end
         if (adc_i == 12'h7FF || adc_i == 12'h800) m_clip = 1;
         mcyc++;
      end
   endtask

   always @(posedge clk) begin
      #1;
      model_step();
      chk("valid", valid_o, longint'(mq.size() > 0));
      chk("ovf", ovf_o, longint'(m_ovf));
      if (mq.size() > 0) begin
         if (!mq[0].tr) chk("data", data_o, mq[0].v);
      end else if (!m_written) begin
         chk("data_rst", data_o, 0);
      end
`ifdef CIC_CLIP_DETECT_EN
      chk("clip", clip_o, longint'(m_clip));
`endif
   end

   function automatic logic [11:0] stim(input int cc);
      case (mode)
         0: return 12'h111;
         1: return ((cc / 4) % 2 == 0) ? 12'h111 : 12'h000;
         2: return 12'h800;
         3: return 12'h7FF;
         default: return 12'($urandom);
      endcase
   endfunction

   task automatic tick(input bit rdy);
      adc_i   = stim(c);
      ready_i = rdy;
      @(negedge clk);
      c++;
   endtask

   task automatic do_reset();
      rstn_i = 0;
      tick(0);
      tick(0);
      rstn_i = 1;
      c = 0;
   endtask

   task automatic lat(input string nm);
      int k;
      k = 0;
      while (!valid_o && k < 20) begin
         tick(1);
         k++;
      end
      chk(nm, k, 9);
   endtask

   task automatic wait_valid(input string nm);
      int k;
      k = 0;
      while (!valid_o && k < 16) begin
         tick(1);
         k++;
      end
      chk(nm, valid_o, 1);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs;
      int xf;
      for (int j = 0; j <= NT; j++) h[j] = 0;
      h[0] = 1;
      for (int s = 1; s <= N; s++) begin
         for (int j = NT; j >= 0; j--) begin
            hs = 0;
            for (int k = 0; k < R; k++)
               if (j - k >= 0) hs += h[j-k];
            h[j] = hs;
         end
      end
      hs = 0;
      for (int j = 0; j <= NT; j++) hs += h[j];
      chk("h_sum", hs, 512);
      chk("h_10", h[10], 48);
      chk("h_4", h[4], 15);

      @(negedge clk);
      mode = 0;
      do_reset();
      chk("rst_valid", valid_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_ovf", ovf_o, 0);
`ifdef CIC_CLIP_DETECT_EN
      chk("rst_clip", clip_o, 0);
`endif

      lat("lat_first");
      while (c < 120) tick(1);
      wait_valid("wv_const");
      chk("const_273", data_o, 4368);
`ifdef CIC_CLIP_DETECT_EN
      chk("clip_none", clip_o, 0);
`endif

      mode = 1;
      do_reset();
      while (c < 120) tick(1);
      wait_valid("wv_square");
      chk("square", data_o, 2184);

      mode = 2;
      do_reset();
      while (c < 120) tick(1);
      wait_valid("wv_min");
      chk("min", data_o, -32768);

      mode = 3;
      do_reset();
      while (c < 120) tick(1);
      wait_valid("wv_max");
      chk("max", data_o, 32752);
`ifdef CIC_CLIP_DETECT_EN
      chk("clip_set", clip_o, 1);
`endif

      mode = 4;
      do_reset();
      while (c < 42) tick(1);
      while (c < 83) tick(0);
      chk("bp_ovf", ovf_o, 1);
      chk("bp_valid", valid_o, 1);
      xf = 0;
      while (c < 87) begin
         if (valid_o) xf++;
         tick(1);
      end
      chk("bp_xfers", xf, 4);
      chk("bp_empty", valid_o, 0);
      chk("bp_ovf_hold", ovf_o, 1);

      do_reset();
      while (c < 42) tick(1);
      while (c < 80) tick(0);
      tick(1);
      chk("fp_ovf", ovf_o, 0);
      chk("fp_valid", valid_o, 1);
      while (c < 84) tick(0);
      xf = 0;
      while (c < 88) begin
         if (valid_o) xf++;
         tick(1);
      end
      chk("fp_xfers", xf, 4);
      chk("fp_empty", valid_o, 0);
      chk("fp_ovf2", ovf_o, 0);

      do_reset();
      while (c < 42) tick(1);
      mode = 3;
      tick(0);
      mode = 4;
      while (c < 70) tick(0);
      chk("mr_pre", valid_o, 1);
`ifdef CIC_CLIP_DETECT_EN
      chk("mr_clip_pre", clip_o, 1);
`endif
      rstn_i = 0;
      tick(0);
      chk("mr_valid", valid_o, 0);
      chk("mr_ovf", ovf_o, 0);
`ifdef CIC_CLIP_DETECT_EN
      chk("mr_clip", clip_o, 0);
`endif
      rstn_i = 1;
      c = 0;
      lat("lat_after_rst");
      repeat (4) tick(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
